// File: rtl/modn_walk_detector.sv
// Modulo-MOD up/down state walker with a registered match flag on a programmable target state.
// Optional saturating hit counter, built only when MODN_WALK_HIT_CNT_EN is defined.
module modn_walk_detector #(
  parameter int unsigned MOD   = 3,
  parameter int unsigned SW    = (MOD > 2) ? $clog2(MOD) : 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IN,
  input  logic             CLR,
  input  logic [SW-1:0]    MATCH_STATE,
  output logic [SW-1:0]    STATE,
  output logic             MATCH,
  output logic [CNT_W-1:0] HIT_CNT
);

  localparam logic [SW-1:0] MaxState = SW'(MOD - 1);
  localparam logic [SW-1:0] OneState = SW'(1);

  logic [SW-1:0] state_q, state_d;
  logic          match_q, match_d;
  logic          on_target;

  // A target at or above MOD is never reached, so MATCH stays low without special casing.
  assign on_target = (state_q == MATCH_STATE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // Explicit compare-and-wrap keeps non-power-of-two MOD inside 0..MOD-1.
  always_comb begin
    state_d = state_q;
    match_d = on_target;
    if (CLR) begin
      state_d = '0;
      match_d = 1'b0;
    end else if (EN) begin
      if (IN) begin
        state_d = (state_q == MaxState) ? '0 : state_q + OneState;
      end else begin
        state_d = (state_q == '0) ? MaxState : state_q - OneState;
      end
    end
  end

  always_comb begin
    STATE = state_q;
    MATCH = match_q;
  end

`ifdef MODN_WALK_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             hit_rise;

  // Counts the edge on which MATCH rises, so dwelling on the target counts once.
  assign hit_rise = !CLR && !match_q && on_target;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (CLR) begin
      hit_cnt_d = '0;
    end else if (hit_rise && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign HIT_CNT = hit_cnt_q;
`else
  assign HIT_CNT = '0;
`endif

endmodule
